core_scheduler: RTL and testbench

Per-core control FSM that sequences one instruction at a time through fetch, decode, memory request/wait, execute and PC update. It drives core_state to the decoder, fetcher, LSUs, ALUs and PCs of one core. It owns the core-wide PC and signals block completion to the dispatcher. All threads of the block share one PC; the PC advances from the last active thread's next_pc.

---
 rtl/core_scheduler.sv | 130 +++++++++++++
 tb/tb_core_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_scheduler.sv
// Per-core instruction sequencer: walks one instruction at a time through
// fetch, decode, memory request/wait, execute and PC update for all lanes.
`timescale 1ns/1ps
module core_scheduler #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int MAX_WAIT          = 255
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [4:0]                     thread_count,
    input  logic [2:0]                     fetcher_state,
    input  logic [2*THREADS_PER_BLOCK-1:0] lsu_state,
    input  logic                           decoded_ret,
    input  logic [8*THREADS_PER_BLOCK-1:0] next_pc,
    output logic [2:0]                     core_state,
    output logic [7:0]                     current_pc,
    output logic                           done,
    output logic                           error,
    output logic [15:0]                    instr_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_REQUEST = 3'b011,
        S_WAIT    = 3'b100,
        S_EXECUTE = 3'b101,
        S_UPDATE  = 3'b110,
        S_DONE    = 3'b111
    } state_t;

    localparam logic [4:0]  TPB      = 5'(THREADS_PER_BLOCK);
    localparam logic [16:0] WAIT_MAX = 17'(MAX_WAIT);
    localparam logic [2:0]  FETCHED  = 3'b010;

    state_t      state_q;
    logic [7:0]  pc_q;
    logic        done_q;
    logic        error_q;
    logic [15:0] instr_q;
    logic [15:0] wait_cnt_q;

    logic [4:0]  eff;
    logic        lanes_busy;
    logic [7:0]  sel_pc;
    logic [16:0] wait_inc;

    always_comb begin
        eff        = (thread_count > TPB) ? TPB : thread_count;
        lanes_busy = 1'b0;
        sel_pc     = next_pc[7:0];
        wait_inc   = {1'b0, wait_cnt_q} + 17'd1;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            // Only lanes below the effective count hold up the core.
            if (5'(i) < eff &&
                (lsu_state[2*i +: 2] == 2'b01 || lsu_state[2*i +: 2] == 2'b10))
                lanes_busy = 1'b1;
            if (5'(i) + 5'd1 == eff)
                sel_pc = next_pc[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= 8'h00;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            instr_q    <= 16'h0000;
            wait_cnt_q <= 16'h0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (eff == 5'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_FETCH;
                            pc_q    <= 8'h00;
                        end
                    end
                end
                S_FETCH: begin
                    if (fetcher_state == FETCHED)
                        state_q <= S_DECODE;
                end
                S_DECODE:  state_q <= S_REQUEST;
                S_REQUEST: begin
                    state_q    <= S_WAIT;
                    wait_cnt_q <= 16'h0000;
                end
                S_WAIT: begin
                    wait_cnt_q <= wait_inc[15:0];
                    // A stuck lane aborts the whole block once the budget is spent.
                    if (lanes_busy && wait_inc >= WAIT_MAX) begin
                        state_q <= S_DONE;
                        error_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else if (!lanes_busy) begin
                        state_q <= S_EXECUTE;
                    end
                end
                S_EXECUTE: state_q <= S_UPDATE;
                S_UPDATE: begin
                    if (instr_q != 16'hFFFF)
                        instr_q <= instr_q + 16'd1;
                    if (decoded_ret) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        pc_q    <= sel_pc;
                        state_q <= S_FETCH;
                    end
                end
                S_DONE:  state_q <= S_DONE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign core_state  = state_q;
    assign current_pc  = pc_q;
    assign done        = done_q;
    assign error       = error_q;
    assign instr_count = instr_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Bench for core_scheduler: two instances (long and short WAIT budget) share
// one stimulus stream and are checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_core_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  tc = 5'd0;
    logic [2:0]  fs = 3'd0;
    logic [7:0]  lsu = 8'd0;
    logic        ret = 1'b0;
    logic [31:0] npc = 32'd0;

    logic [2:0]  a_st, b_st;
    logic [7:0]  a_pc, b_pc;
    logic        a_dn, b_dn, a_er, b_er;
    logic [15:0] a_ic, b_ic;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    core_scheduler #(.THREADS_PER_BLOCK(4), .MAX_WAIT(255)) dut_a (
        .clk(clk), .reset(reset), .start(start), .thread_count(tc),
        .fetcher_state(fs), .lsu_state(lsu), .decoded_ret(ret), .next_pc(npc),
        .core_state(a_st), .current_pc(a_pc), .done(a_dn), .error(a_er),
        .instr_count(a_ic));

    core_scheduler #(.THREADS_PER_BLOCK(4), .MAX_WAIT(4)) dut_b (
        .clk(clk), .reset(reset), .start(start), .thread_count(tc),
        .fetcher_state(fs), .lsu_state(lsu), .decoded_ret(ret), .next_pc(npc),
        .core_state(b_st), .current_pc(b_pc), .done(b_dn), .error(b_er),
        .instr_count(b_ic));

    typedef struct {
        int         st;
        logic [7:0] pc;
        bit         dn;
        bit         er;
        int         ic;
        int         wc;
    } mdl_t;

    localparam int IDLE = 0, FETCH = 1, DECODE = 2, REQUEST = 3,
                   WAITS = 4, EXECUTE = 5, UPDATE = 6, DONE = 7;

    function automatic mdl_t fresh();
        mdl_t m;
        m.st = IDLE; m.pc = 8'h00; m.dn = 1'b0; m.er = 1'b0; m.ic = 0; m.wc = 0;
        return m;
    endfunction

    // One clock of the block's rules, in plain arithmetic on the current inputs.
    function automatic mdl_t step(mdl_t m, int maxw);
        int eff;
        int busy;
        eff  = (int'(tc) < 4) ? int'(tc) : 4;
        busy = 0;
        for (int i = 0; i < eff; i++)
            if (lsu[2*i +: 2] == 2'b01 || lsu[2*i +: 2] == 2'b10) busy++;
        case (m.st)
            IDLE:    if (start) begin
                         if (eff == 0) begin m.st = DONE; m.dn = 1'b1; end
                         else begin m.st = FETCH; m.pc = 8'h00; end
                     end
            FETCH:   if (fs == 3'b010) m.st = DECODE;
            DECODE:  m.st = REQUEST;
            REQUEST: begin m.st = WAITS; m.wc = 0; end
            WAITS:   begin
                         m.wc = m.wc + 1;
                         if (busy > 0 && m.wc >= maxw) begin
                             m.st = DONE; m.er = 1'b1; m.dn = 1'b1;
                         end else if (busy == 0) m.st = EXECUTE;
                     end
            EXECUTE: m.st = UPDATE;
            UPDATE:  begin
                         m.ic = (m.ic < 65535) ? m.ic + 1 : 65535;
                         if (ret) begin m.st = DONE; m.dn = 1'b1; end
                         else begin
                             if (eff > 0) m.pc = npc[8*(eff-1) +: 8];
                             m.st = FETCH;
                         end
                     end
            default: m.st = DONE;
        endcase
        return m;
    endfunction

    mdl_t ma = fresh();
    mdl_t mb = fresh();

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma <= fresh();
            mb <= fresh();
        end else begin
            ma <= step(ma, 255);
            mb <= step(mb, 4);
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("a.state", int'(a_st), ma.st);
        cmp("a.pc",    int'(a_pc), int'(ma.pc));
        cmp("a.done",  int'(a_dn), int'(ma.dn));
        cmp("a.error", int'(a_er), int'(ma.er));
        cmp("a.icnt",  int'(a_ic), ma.ic);
        cmp("b.state", int'(b_st), mb.st);
        cmp("b.pc",    int'(b_pc), int'(mb.pc));
        cmp("b.done",  int'(b_dn), int'(mb.dn));
        cmp("b.error", int'(b_er), int'(mb.er));
        cmp("b.icnt",  int'(b_ic), mb.ic);
    end

    int scn = 0;
    int p = 99;
    int fstall = 0;

    // Scenario-dependent input drive, applied just after a falling edge.
    task automatic apply();
        start = 1'b1;
        case (scn)
            2: begin
                tc = 5'd4; fs = 3'b010; lsu = 8'h00;
                npc = {ma.pc + 8'd1, 8'hEE, 8'hDD, 8'hCC};
                ret = (ma.pc == 8'd2);
            end
            3: begin
                tc = 5'd4; ret = 1'b1; npc = 32'h0403_0201;
                if (ma.st == FETCH && fstall > 0) begin fs = 3'b001; fstall--; end
                else fs = 3'b010;
                if (ma.st == REQUEST) p = 0;
                else if (ma.st == WAITS) p = p + 1;
                else p = 99;
                lsu = 8'h00;
                if (p < 2) lsu[3:2] = 2'b01;
                else if (p < 5) lsu[3:2] = 2'b10;
                else if (p < 99) lsu[3:2] = 2'b11;
            end
            4: begin
                tc = 5'd2; fs = 3'b010; lsu = 8'b01_00_00_00;
                npc = {8'h55, 8'h33, 8'h20, 8'h11};
                ret = (ma.pc == 8'h20);
            end
            5: begin
                tc = 5'd9; fs = 3'b010; lsu = 8'h00;
                npc = {8'hA7, 8'h33, 8'h22, 8'h01};
                ret = (ma.pc == 8'hA7);
            end
            6: begin tc = 5'd0; fs = 3'b010; lsu = 8'h00; ret = 1'b0; end
            default: begin tc = 5'd1; fs = 3'b010; lsu = 8'b00_00_00_10; ret = 1'b0; end
        endcase
    endtask

    task automatic restart(input int s);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        scn = s;
    endtask

    // Runs until instance A reports done; returns cycles taken and A's WAIT cycles.
    task automatic run_block(input string name, input int bound, output int n, output int waits);
        n = 0; waits = 0;
        do begin
            apply();
            @(negedge clk);
            n++;
            if (a_st == 3'd4) waits++;
        end while (!a_dn && n < bound);
        if (!a_dn) cmp({name, ".timeout"}, 0, 1);
    endtask

    int n, w;

    initial begin
        // Reset held with arbitrary inputs.
        scn = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'($urandom); tc = 5'($urandom); fs = 3'($urandom);
            lsu = 8'($urandom); ret = 1'($urandom); npc = $urandom;
        end
        @(negedge clk);
        cmp("rst.state", int'(a_st), 0);
        cmp("rst.pc", int'(a_pc), 0);
        cmp("rst.done_err", int'({a_dn, a_er}), 0);
        cmp("rst.icnt", int'(a_ic), 0);

        restart(2);
        run_block("alu", 60, n, w);
        cmp("alu.cycles", n, 19);
        cmp("alu.pc", int'(a_pc), 2);
        cmp("alu.icnt", int'(a_ic), 3);
        cmp("alu.waits", w, 3);
        cmp("alu.state", int'(a_st), 7);

        restart(3);
        fstall = 2;
        run_block("mem", 60, n, w);
        cmp("mem.waits", w, 5);
        cmp("mem.a_icnt", int'(a_ic), 1);
        cmp("mem.a_err", int'(a_er), 0);
        cmp("tmo.b_err", int'(b_er), 1);
        cmp("tmo.b_done", int'(b_dn), 1);
        cmp("tmo.b_icnt", int'(b_ic), 0);

        restart(4);
        run_block("part", 60, n, w);
        cmp("part.pc", int'(a_pc), 8'h20);
        cmp("part.waits", w, 2);
        cmp("part.icnt", int'(a_ic), 2);

        restart(5);
        run_block("tc9", 60, n, w);
        cmp("tc9.pc", int'(a_pc), 8'hA7);
        cmp("tc9.icnt", int'(a_ic), 2);

        restart(6);
        run_block("empty", 10, n, w);
        cmp("empty.cycles", n, 1);
        cmp("empty.state", int'(a_st), 7);
        cmp("empty.icnt", int'(a_ic), 0);

        // Asynchronous reset while stuck in WAIT.
        restart(7);
        n = 0;
        do begin apply(); @(negedge clk); n++; end while (a_st != 3'd4 && n < 20);
        cmp("arst.reached_wait", int'(a_st), 4);
        #2 reset = 1'b0;
        #1;
        cmp("arst.a_state", int'(a_st), 0);
        cmp("arst.b_state", int'(b_st), 0);
        @(negedge clk);
        reset = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        cmp("arst.idle", int'(a_st), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
